gain_ramp_stage: RTL and testbench
==================================

// Module: gain_ramp_stage
// PURPOSE
//   Multi-channel, time-multiplexed AXI-Stream gain stage with per-channel target gain and
//   linear gain ramping (zipper-noise-free volume changes), output saturation and clip
//   telemetry. Sits in the DSP chain between the audio source and the effect/DAC path.
//   It is the parametrised successor of the single-channel fixed-gain stage.
// PARAMETERS
//   G_INTEGER_BITS  16  integer bits of unsigned gain word
//   G_DECIMAL_BITS  16  fractional bits of gain word (1.0 = 1<<G_DECIMAL_BITS)
//   G_DWIDTH        24  signed sample width, in and out
//   G_NUM_CH        2   channels sharing the stream; CW = max(1,$clog2(G_NUM_CH))
// PORTS  (GW = G_INTEGER_BITS+G_DECIMAL_BITS)
//   clk          in   1            clock, all logic rising-edge
//   reset        in   1            synchronous, active-low (0 = reset)
//   enable       in   1            1 = run; 0 = flush pipeline, freeze gains
//   gain_target  in   G_NUM_CH*GW  per-ch target gain, ch c at [c*GW +: GW], unsigned
//   ramp_step    in   GW           gain change per accepted sample; 0 = jump to target
//   clip_clear   in   1            1-cycle pulse clears clip_count and clip_flag
//   din          in   G_DWIDTH     signed sample
//   din_chan     in   CW           channel index of din
//   din_valid    in   1            AXIS valid
//   din_ready    out  1            AXIS ready
//   dout         out  G_DWIDTH     signed, saturated result
//   dout_chan    out  CW           channel index of dout
//   dout_valid   out  1            AXIS valid
//   dout_ready   in   1            AXIS ready
//   clip_flag    out  1            sticky: any saturation since last clear
//   clip_count   out  16           saturating count of clipped samples
// BEHAVIOUR
//   Reset (reset=0 at edge): all pipeline valids 0, dout/dout_chan 0, clip_flag 0,
//     clip_count 0, every cur_gain[c] = 1.0. din_ready = 0 during reset.
//   Pipeline: 3 stages S1 input reg -> S2 multiply -> S3 saturate/output reg.
//     adv = enable & (~dout_valid | dout_ready); all stages shift together on adv.
//     din_ready = adv (combinational). Latency 3 cycles din accept -> dout_valid, full
//     throughput 1 sample/clk. dout/dout_chan held stable while dout_valid & ~dout_ready.
//   Gain ramp: on accept of sample on ch c, sample uses cur_gain[c] (pre-update value);
//     same cycle cur_gain[c] moves toward target[c] by ramp_step, clamped to target (no
//     overshoot, no wrap). ramp_step = 0 -> cur_gain[c] = target[c] immediately and that
//     sample still uses the old value. Idle channels do not ramp.
//   Channel b2b: consecutive samples on same ch see successive ramp values (no hazard).
//   din_chan >= G_NUM_CH: sample passes with gain 0 (dout = 0), no gain update, no clip.
//   Arithmetic: prod = signed(din) * signed({1'b0,cur_gain}) full width
//     G_DWIDTH+GW+1; shifted = prod >>> G_DECIMAL_BITS (floor, toward -inf).
//     shifted > 2^(G_DWIDTH-1)-1 -> dout = 2^(G_DWIDTH-1)-1, clip;
//     shifted < -2^(G_DWIDTH-1) -> dout = -2^(G_DWIDTH-1), clip; else low G_DWIDTH bits.
//   Clip: evaluated when sample enters S3; clip_flag set, clip_count +1 saturating at
//     0xFFFF. clip_clear same cycle as a clip: clear wins, that clip is dropped.
//   enable=0: din_ready=0, all valids cleared next edge (in-flight samples discarded),
//     dout_valid=0, cur_gain frozen, clip stats kept. Resumes cleanly on enable=1.
//   gain_target changes mid-ramp: ramp redirects toward new target from cur value.
//   Mid-operation reset: same as reset above; in-flight data discarded, no partial output.
// TESTING
//   T1 unity: G_NUM_CH=2, targets 1.0, din 1000/-1000 alt ch -> dout 1000/-1000, lat 3.
//   T2 ramp: ch0 cur 1.0, target 2.0, step 0x4000, din=1000 x6 ->
//      dout 1000,1250,1500,1750,2000,2000; ch1 interleaved at 1.0 stays 1000.
//   T3 saturate: gain 4.0, din 0x300000 -> 0x7FFFFF; din 0xD00000 -> 0x800000;
//      clip_count=2, clip_flag=1; clip_clear -> both 0.
//   T4 backpressure: dout_ready random 50%, 200 samples -> no loss/dup, order and
//      dout_chan preserved, dout stable while stalled, ramp advances per accept only.
//   T5 reset/enable: reset=0 mid-stream -> dout_valid 0 next clk, gains 1.0; enable=0
//      with 3 in flight -> no output, gains unchanged after re-enable.
//   T6 bad channel: G_NUM_CH=3, din_chan=3, din=500 -> dout 0, dout_chan 3, no clip.

Source files
------------

// File: rtl/gain_ramp_stage.sv
// Multi-channel AXI-Stream gain stage with per-channel linear gain ramping, output
// saturation and clip telemetry. Pipeline: S1 capture -> S2 multiply -> S3 saturate/output.
module gain_ramp_stage #(
  parameter int unsigned G_INTEGER_BITS = 16,
  parameter int unsigned G_DECIMAL_BITS = 16,
  parameter int unsigned G_DWIDTH       = 24,
  parameter int unsigned G_NUM_CH       = 2,
  localparam int unsigned GW = G_INTEGER_BITS + G_DECIMAL_BITS,
  localparam int unsigned CW = (G_NUM_CH > 1) ? $clog2(G_NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [G_NUM_CH*GW-1:0] gain_target,
  input  logic [GW-1:0]          ramp_step,
  input  logic                   clip_clear,
  input  logic [G_DWIDTH-1:0]    din,
  input  logic [CW-1:0]          din_chan,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [G_DWIDTH-1:0]    dout,
  output logic [CW-1:0]          dout_chan,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   clip_flag,
  output logic [15:0]            clip_count
);

  localparam int unsigned PW = G_DWIDTH + GW + 1;
  localparam logic [GW-1:0] GainOne = GW'(1) << G_DECIMAL_BITS;

  // One ramp step from cur toward tgt, clamped at tgt; step 0 jumps straight to tgt.
  function automatic logic [GW-1:0] ramp_next(input logic [GW-1:0] cur,
                                              input logic [GW-1:0] tgt,
                                              input logic [GW-1:0] step);
    logic [GW-1:0] nxt;
    nxt = cur;
    if (step == '0) begin
      nxt = tgt;
    end else if (cur < tgt) begin
      nxt = ((tgt - cur) <= step) ? tgt : cur + step;
    end else if (cur > tgt) begin
      nxt = ((cur - tgt) <= step) ? tgt : cur - step;
    end
    return nxt;
  endfunction

  logic [GW-1:0]              cur_gain_q [G_NUM_CH];
  logic [GW-1:0]              cur_gain_d [G_NUM_CH];
  logic                       s1_valid_q, s2_valid_q, dout_valid_q;
  logic signed [G_DWIDTH-1:0] s1_data_q;
  logic [GW-1:0]              s1_gain_q;
  logic [CW-1:0]              s1_chan_q, s2_chan_q, dout_chan_q;
  logic signed [PW-1:0]       s2_prod_q;
  logic signed [PW-1:0]       prod, prod_sh;
  logic [G_DWIDTH-1:0]        dout_q, sat_val;
  logic                       clip, adv, accept;
  logic [GW-1:0]              sel_gain;
  logic                       clip_flag_q;
  logic [15:0]                clip_count_q;

  always_comb begin
    adv       = enable & (~dout_valid_q | dout_ready);
    din_ready = adv & reset;
    accept    = din_valid & din_ready;
    // Out-of-range channels leave sel_gain at zero so the sample is muted.
    sel_gain  = '0;
    for (int unsigned c = 0; c < G_NUM_CH; c++) begin
      cur_gain_d[c] = cur_gain_q[c];
      if (32'(din_chan) == c) begin
        sel_gain = cur_gain_q[c];
        if (accept) begin
          cur_gain_d[c] = ramp_next(cur_gain_q[c], gain_target[c*GW +: GW], ramp_step);
        end
      end
    end
  end

  always_comb begin
    prod    = PW'(s1_data_q) * PW'($signed({1'b0, s1_gain_q}));
    prod_sh = s2_prod_q >>> G_DECIMAL_BITS;
    clip    = 1'b0;
    sat_val = prod_sh[G_DWIDTH-1:0];
    // Result fits only if every bit from the output sign bit upward agrees.
    if (!((&prod_sh[PW-1:G_DWIDTH-1]) || !(|prod_sh[PW-1:G_DWIDTH-1]))) begin
      clip    = 1'b1;
      sat_val = prod_sh[PW-1] ? {1'b1, {(G_DWIDTH-1){1'b0}}} : {1'b0, {(G_DWIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned c = 0; c < G_NUM_CH; c++) begin
        cur_gain_q[c] <= GainOne;
      end
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      s1_data_q    <= '0;
      s1_gain_q    <= '0;
      s1_chan_q    <= '0;
      s2_chan_q    <= '0;
      s2_prod_q    <= '0;
      dout_q       <= '0;
      dout_chan_q  <= '0;
      clip_flag_q  <= 1'b0;
      clip_count_q <= '0;
    end else begin
      cur_gain_q <= cur_gain_d;
      if (!enable) begin
        s1_valid_q   <= 1'b0;
        s2_valid_q   <= 1'b0;
        dout_valid_q <= 1'b0;
      end else if (adv) begin
        s1_valid_q   <= din_valid;
        s1_data_q    <= din;
        s1_chan_q    <= din_chan;
        s1_gain_q    <= sel_gain;
        s2_valid_q   <= s1_valid_q;
        s2_prod_q    <= prod;
        s2_chan_q    <= s1_chan_q;
        dout_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          dout_q      <= sat_val;
          dout_chan_q <= s2_chan_q;
        end
      end
      if (clip_clear) begin
        clip_flag_q  <= 1'b0;
        clip_count_q <= '0;
      end else if (adv && s2_valid_q && clip) begin
        clip_flag_q <= 1'b1;
        if (clip_count_q != 16'hFFFF) begin
          clip_count_q <= clip_count_q + 16'd1;
        end
      end
    end
  end

  assign dout       = dout_q;
  assign dout_chan  = dout_chan_q;
  assign dout_valid = dout_valid_q;
  assign clip_flag  = clip_flag_q;
  assign clip_count = clip_count_q;

endmodule

// File: tb/tb_gain_ramp_stage.sv
// Bench for gain_ramp_stage: directed and random stimulus scored against an
// arithmetic reference model of the gain, ramp and saturation rules.
module tb_gain_ramp_stage;
  localparam int unsigned IB = 16, DB = 16, DW = 24, NCH = 3, GW = 32, CW = 2;
  localparam longint ONE  = 64'h10000;
  localparam longint MAXV = 64'sd8388607;
  localparam longint MINV = -64'sd8388608;

  logic              clk = 1'b0;
  logic              reset, enable, clip_clear, din_valid, din_ready;
  logic              dout_valid, dout_ready, clip_flag;
  logic [NCH*GW-1:0] gain_target;
  logic [GW-1:0]     ramp_step;
  logic [DW-1:0]     din, dout;
  logic [CW-1:0]     din_chan, dout_chan;
  logic [15:0]       clip_count;

  gain_ramp_stage #(
    .G_INTEGER_BITS(IB), .G_DECIMAL_BITS(DB), .G_DWIDTH(DW), .G_NUM_CH(NCH)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .gain_target(gain_target),
    .ramp_step(ramp_step), .clip_clear(clip_clear), .din(din), .din_chan(din_chan),
    .din_valid(din_valid), .din_ready(din_ready), .dout(dout), .dout_chan(dout_chan),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .clip_flag(clip_flag),
    .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  typedef struct { longint y; int ch; bit clip; int acc_cyc; } exp_t;
  exp_t   exp_q[$];
  longint m_gain[NCH], m_tgt[NCH], m_step;
  int     m_clip = 0;
  int     checks = 0, failures = 0, cyc = 0, n_out = 0;
  bit     check_lat, accepted, stall_prev;
  logic [DW-1:0] prev_dout;
  logic [CW-1:0] prev_chan;
  longint cap_d[$];
  int     cap_c[$];
  longint t1_exp[4] = '{1000, -1000, 1000, -1000};
  longint t2_exp[6] = '{1000, 1250, 1500, 1750, 2000, 2000};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_cfg();
    for (int c = 0; c < NCH; c++) gain_target[c*GW +: GW] = GW'(m_tgt[c]);
    ramp_step = GW'(m_step);
  endtask

  // Mid-cycle observation of both handshakes, feeding the reference model.
  task automatic sample();
    exp_t e;
    longint y, g, t;
    if (stall_prev) begin
      chk("stall_valid", 64'(dout_valid), 64'd1);
      chk("stall_dout", 64'(dout), 64'(prev_dout));
      chk("stall_chan", 64'(dout_chan), 64'(prev_chan));
    end
    accepted = 1'b0;
    if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
      n_out++;
      cap_d.push_back(longint'($signed(dout)));
      cap_c.push_back(int'(dout_chan));
      if (exp_q.size() == 0) chk("spurious_out", 64'(dout_valid), 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("dout", 64'(dout), 64'(e.y) & 64'hFFFFFF);
        chk("dout_chan", 64'(dout_chan), 64'(e.ch));
        if (check_lat) chk("latency", 64'(cyc - e.acc_cyc), 64'd3);
        if (e.clip) m_clip++;
      end
    end
    if (din_valid === 1'b1 && din_ready === 1'b1) begin
      accepted  = 1'b1;
      e.ch      = int'(din_chan);
      e.acc_cyc = cyc;
      e.clip    = 1'b0;
      y         = 0;
      if (e.ch < NCH) begin
        g = m_gain[e.ch];
        t = m_tgt[e.ch];
        y = (longint'($signed(din)) * g) >>> DB;
        if (y > MAXV) begin y = MAXV; e.clip = 1'b1; end
        if (y < MINV) begin y = MINV; e.clip = 1'b1; end
        if (m_step == 0) g = t;
        else if (g < t) g = (g + m_step > t) ? t : g + m_step;
        else if (g > t) g = (g - m_step < t) ? t : g - m_step;
        m_gain[e.ch] = g;
      end
      e.y = y;
      exp_q.push_back(e);
    end
    if (reset === 1'b0) begin
      exp_q.delete();
      for (int c = 0; c < NCH; c++) m_gain[c] = ONE;
      m_clip = 0;
    end else if (enable === 1'b0) begin
      exp_q.delete();
    end
    stall_prev = (reset === 1'b1 && enable === 1'b1 && dout_valid === 1'b1 &&
                  dout_ready === 1'b0);
    prev_dout = dout;
    prev_chan = dout_chan;
  endtask

  task automatic tick();
    #4;
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input int ch, input longint d, input bit rnd_ready);
    din       = d[DW-1:0];
    din_chan  = ch[CW-1:0];
    din_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (rnd_ready) dout_ready = 1'($urandom_range(0, 1));
      tick();
      if (accepted) break;
    end
    chk("send_accept", 64'(accepted), 64'd1);
    din_valid = 1'b0;
  endtask

  task automatic drain();
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    chk("drain", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  task automatic clr_cap();
    cap_d.delete();
    cap_c.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int k;
    reset = 1'b0; enable = 1'b1; clip_clear = 1'b0; din = '0; din_chan = '0;
    din_valid = 1'b0; dout_ready = 1'b1; check_lat = 1'b1; stall_prev = 1'b0;
    for (int c = 0; c < NCH; c++) begin m_tgt[c] = ONE; m_gain[c] = ONE; end
    m_step = 0;
    apply_cfg();
    tick(); tick();
    chk("rst_dout_valid", 64'(dout_valid), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_dout_chan", 64'(dout_chan), 64'd0);
    chk("rst_clip_flag", 64'(clip_flag), 64'd0);
    chk("rst_clip_count", 64'(clip_count), 64'd0);
    chk("rst_din_ready", 64'(din_ready), 64'd0);
    reset = 1'b1;

    // T1 unity gain, alternating channels
    clr_cap();
    for (int i = 0; i < 4; i++) send(i % 2, t1_exp[i], 1'b0);
    drain();
    chk("t1_count", 64'(cap_d.size()), 64'd4);
    for (int i = 0; i < 4 && i < cap_d.size(); i++) chk("t1_val", cap_d[i], t1_exp[i]);

    // T2 ramp ch0 1.0 -> 2.0 in 0.25 steps, ch1 held at 1.0
    m_tgt[0] = 64'h20000; m_tgt[1] = ONE; m_step = 64'h4000;
    apply_cfg();
    clr_cap();
    for (int i = 0; i < 6; i++) begin send(0, 1000, 1'b0); send(1, 1000, 1'b0); end
    drain();
    k = 0;
    for (int i = 0; i < cap_d.size(); i++) begin
      if (cap_c[i] == 0 && k < 6) begin chk("t2_ch0", cap_d[i], t2_exp[k]); k++; end
      else chk("t2_ch1", cap_d[i], 64'd1000);
    end
    chk("t2_ch0_count", 64'(k), 64'd6);

    // T3 saturation at gain 4.0 on ch2 (first sample still sees 1.0)
    m_tgt[2] = 64'h40000; m_step = 0;
    apply_cfg();
    clr_cap();
    send(2, 0, 1'b0); send(2, 64'h300000, 1'b0); send(2, 64'hD00000, 1'b0);
    drain();
    chk("t3_count", 64'(cap_d.size()), 64'd3);
    if (cap_d.size() == 3) begin
      chk("t3_pos_sat", cap_d[1], MAXV);
      chk("t3_neg_sat", cap_d[2], MINV);
    end
    chk("t3_clip_count", 64'(clip_count), 64'd2);
    chk("t3_clip_flag", 64'(clip_flag), 64'd1);
    clip_clear = 1'b1; tick(); clip_clear = 1'b0;
    m_clip = 0;
    chk("t3_clr_count", 64'(clip_count), 64'd0);
    chk("t3_clr_flag", 64'(clip_flag), 64'd0);
    // Clear coinciding with a clip entering the output stage wins.
    send(2, 64'h300000, 1'b0);
    tick();
    clip_clear = 1'b1; tick(); clip_clear = 1'b0;
    drain();
    m_clip = 0;
    chk("t3_clr_race_count", 64'(clip_count), 64'd0);
    chk("t3_clr_race_flag", 64'(clip_flag), 64'd0);

    // T4 random traffic with 50% backpressure and retargeting
    check_lat = 1'b0;
    nb = n_out;
    for (int s = 0; s < 200; s++) begin
      if (s % 40 == 0) begin
        for (int c = 0; c < NCH; c++) m_tgt[c] = longint'($urandom_range(0, 'h30000));
        m_step = ($urandom_range(0, 3) == 0) ? 0 : longint'($urandom_range(1, 'h8000));
        apply_cfg();
      end
      if ($urandom_range(0, 3) == 0) begin
        dout_ready = 1'($urandom_range(0, 1));
        tick();
      end
      send(int'($urandom_range(0, 3)), longint'($urandom_range(0, 'hFFFFFF)), 1'b1);
    end
    drain();
    chk("t4_out_count", 64'(n_out - nb), 64'd200);
    chk("t4_clip_count", 64'(clip_count), 64'((m_clip > 65535) ? 65535 : m_clip));
    chk("t4_clip_flag", 64'(clip_flag), 64'(m_clip != 0));
    check_lat = 1'b1;

    // T5a reset mid-stream
    m_tgt[0] = 64'h20000; m_step = 64'h2000;
    apply_cfg();
    for (int i = 0; i < 5; i++) send(0, 1000, 1'b0);
    reset = 1'b0;
    tick();
    chk("t5_rst_dout_valid", 64'(dout_valid), 64'd0);
    chk("t5_rst_din_ready", 64'(din_ready), 64'd0);
    chk("t5_rst_clip_count", 64'(clip_count), 64'd0);
    reset = 1'b1;
    clr_cap();
    send(0, 1000, 1'b0); send(0, 1000, 1'b0);
    drain();
    chk("t5_rst_count", 64'(cap_d.size()), 64'd2);
    if (cap_d.size() == 2) begin
      chk("t5_rst_gain_one", cap_d[0], 64'd1000);
      chk("t5_rst_ramp", cap_d[1], 64'd1125);
    end

    // T5b disable with three samples in flight
    m_tgt[1] = 64'h30000; m_step = 64'h1000;
    apply_cfg();
    for (int i = 0; i < 3; i++) send(1, 100, 1'b0);
    enable = 1'b0; dout_ready = 1'b0;
    nb = n_out;
    tick();
    dout_ready = 1'b1;
    tick(); tick(); tick();
    chk("t5_dis_outputs", 64'(n_out - nb), 64'd0);
    chk("t5_dis_dout_valid", 64'(dout_valid), 64'd0);
    chk("t5_dis_din_ready", 64'(din_ready), 64'd0);
    enable = 1'b1;
    clr_cap();
    send(1, 1000, 1'b0);
    drain();
    chk("t5_resume_count", 64'(cap_d.size()), 64'd1);
    if (cap_d.size() == 1) chk("t5_resume_gain", cap_d[0], 64'd1187);

    // T6 out-of-range channel
    clr_cap();
    send(3, 500, 1'b0);
    drain();
    chk("t6_count", 64'(cap_d.size()), 64'd1);
    if (cap_d.size() == 1) begin
      chk("t6_dout", cap_d[0], 64'd0);
      chk("t6_chan", 64'(cap_c[0]), 64'd3);
    end
    chk("t6_clip_count", 64'(clip_count), 64'(m_clip));
    chk("t6_clip_flag", 64'(clip_flag), 64'(m_clip != 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
